issue_ctrl: RTL and testbench

- Instruction queue and issue sequencer between ifetch and the combinational decoder.
- Buffers fetched instructions and presents the head to the decoder.
- Asserts the decoder's `inst_rdy` only when the target structures have space: ROB always, plus RS or LSB depending on opcode class.
- Handles rollback flush and program halt.

---
 rtl/issue_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_issue_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// Purpose : instruction queue and issue sequencer between ifetch and the decoder.
// Latency : a pushed instruction is issuable one cycle after its push edge (no bypass).
// Backpressure: if_full holds ifetch; issue waits for ROB plus RS or LSB space per opcode class.
//
// Ports:
//   clk, rst (async, active-low), rdy (global enable), rollback (flush)
//   if_valid/if_inst/if_pc/if_is_jump -> queue push side, if_full back to ifetch
//   dec_inst_rdy/dec_inst/dec_pc/dec_is_jump -> head of queue to the decoder
//   rob_full/rs_full/lsb_full -> downstream space, issue_fire/halted/count status
// Optional: define ISSUE_STAT_EN to add stat_issued/stat_stall_rob/stat_stall_unit.

module issue_ctrl #(
  parameter int          QUEUE_LOG = 2,
  parameter logic [31:0] HALT_INST = 32'h0ff00513
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 if_valid,
  input  logic [31:0]          if_inst,
  input  logic [31:0]          if_pc,
  input  logic                 if_is_jump,
  output logic                 if_full,
  output logic                 dec_inst_rdy,
  output logic [31:0]          dec_inst,
  output logic [31:0]          dec_pc,
  output logic                 dec_is_jump,
  input  logic                 rob_full,
  input  logic                 rs_full,
  input  logic                 lsb_full,
  output logic                 issue_fire,
  output logic                 halted,
  output logic [QUEUE_LOG:0]   count
`ifdef ISSUE_STAT_EN
  ,
  output logic [31:0]          stat_issued,
  output logic [31:0]          stat_stall_rob,
  output logic [31:0]          stat_stall_unit
`endif
);

  localparam int                 DEPTH   = 1 << QUEUE_LOG;
  localparam logic [QUEUE_LOG:0] DEPTH_C = (QUEUE_LOG + 1)'(DEPTH);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [QUEUE_LOG-1:0]   head_q, head_d;
  logic [QUEUE_LOG-1:0]   tail_q, tail_d;
  logic [QUEUE_LOG:0]     count_q, count_d;
  logic [31:0]            inst_mem_q [DEPTH];
  logic [31:0]            inst_mem_d [DEPTH];
  logic [31:0]            pc_mem_q   [DEPTH];
  logic [31:0]            pc_mem_d   [DEPTH];
  logic                   jmp_mem_q  [DEPTH];
  logic                   jmp_mem_d  [DEPTH];

  logic       push;
  logic       pop;
  logic       in_run;
  logic       not_empty;
  logic       is_lsb_class;
  logic       is_lui;
  logic       unit_full;
  logic [6:0] head_opc;

  // Head entry and its opcode class.
  always_comb begin
    dec_inst     = inst_mem_q[head_q];
    dec_pc       = pc_mem_q[head_q];
    dec_is_jump  = jmp_mem_q[head_q];
    head_opc     = dec_inst[6:0];
    is_lsb_class = (head_opc == OPC_LOAD) || (head_opc == OPC_STORE);
    is_lui       = (head_opc == OPC_LUI);
    // LUI needs only a ROB entry; memory ops need the LSB; everything else the RS.
    unit_full    = is_lsb_class ? lsb_full : (is_lui ? 1'b0 : rs_full);
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (rdy) begin
      case (state_q)
        ST_RUN: begin
          if (rollback)
            state_d = ST_FLUSH;
          else if (pop && (dec_inst == HALT_INST))
            state_d = ST_HALT;
        end
        // One dead cycle so the ROB and RS can finish clearing.
        ST_FLUSH: state_d = ST_RUN;
        // A halt may sit on a mispredicted path, so rollback still escapes it.
        ST_HALT:  if (rollback) state_d = ST_FLUSH;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_run    = (state_q == ST_RUN);
    halted    = (state_q == ST_HALT);
    not_empty = (count_q != '0);
    if_full   = (count_q == DEPTH_C);
    // rst is folded in so the issue request drops the instant reset asserts.
    dec_inst_rdy = rdy & rst & in_run & not_empty & ~rollback & ~rob_full & ~unit_full;
    issue_fire   = dec_inst_rdy;
    pop          = dec_inst_rdy;
    push         = rdy & if_valid & ~if_full & ~rollback & in_run;
    count        = count_q;
  end

  // ---------------- queue datapath ----------------
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      inst_mem_d[i] = inst_mem_q[i];
      pc_mem_d[i]   = pc_mem_q[i];
      jmp_mem_d[i]  = jmp_mem_q[i];
    end
    if (rdy && rollback) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push) begin
        inst_mem_d[tail_q] = if_inst;
        pc_mem_d[tail_q]   = if_pc;
        jmp_mem_d[tail_q]  = if_is_jump;
        tail_d             = tail_q + QUEUE_LOG'(1);
      end
      if (pop)
        head_d = head_q + QUEUE_LOG'(1);
      count_d = count_q + (QUEUE_LOG + 1)'(push) - (QUEUE_LOG + 1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
        jmp_mem_q[i]  <= 1'b0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= inst_mem_d[i];
        pc_mem_q[i]   <= pc_mem_d[i];
        jmp_mem_q[i]  <= jmp_mem_d[i];
      end
    end
  end

`ifdef ISSUE_STAT_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_stall_rob_q, stat_stall_rob_d;
  logic [31:0] stat_stall_unit_q, stat_stall_unit_d;

  // Counters survive rollback; only reset clears them.
  always_comb begin
    stat_issued_d     = stat_issued_q;
    stat_stall_rob_d  = stat_stall_rob_q;
    stat_stall_unit_d = stat_stall_unit_q;
    if (issue_fire)
      stat_issued_d = stat_issued_q + 32'd1;
    if (rdy && in_run && not_empty && rob_full)
      stat_stall_rob_d = stat_stall_rob_q + 32'd1;
    if (rdy && in_run && not_empty && !rob_full && unit_full)
      stat_stall_unit_d = stat_stall_unit_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_issued_q     <= '0;
      stat_stall_rob_q  <= '0;
      stat_stall_unit_q <= '0;
    end else begin
      stat_issued_q     <= stat_issued_d;
      stat_stall_rob_q  <= stat_stall_rob_d;
      stat_stall_unit_q <= stat_stall_unit_d;
    end
  end

  assign stat_issued     = stat_issued_q;
  assign stat_stall_rob  = stat_stall_rob_q;
  assign stat_stall_unit = stat_stall_unit_q;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed stimulus for issue_ctrl with an issue scoreboard.
// The stimulus process queues every instruction it expects to be issued;
// a monitor pops and compares on each issue_fire.

module tb_issue_ctrl;

  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] LW   = 32'h0000a103;
  localparam logic [31:0] SW   = 32'h00112023;
  localparam logic [31:0] LUI  = 32'h000010b7;
  localparam logic [31:0] HALT = 32'h0ff00513;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        rollback = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_inst = '0;
  logic [31:0] if_pc = '0;
  logic        if_is_jump = 1'b0;
  logic        if_full;
  logic        dec_inst_rdy;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_is_jump;
  logic        rob_full = 1'b0;
  logic        rs_full = 1'b0;
  logic        lsb_full = 1'b0;
  logic        issue_fire;
  logic        halted;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        jmp;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;

  issue_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_is_jump(if_is_jump),
    .if_full(if_full), .dec_inst_rdy(dec_inst_rdy), .dec_inst(dec_inst),
    .dec_pc(dec_pc), .dec_is_jump(dec_is_jump),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .issue_fire(issue_fire), .halted(halted), .count(count)
  );

  always #5 clk = ~clk;

  // Issue monitor: every issue must match the oldest expected instruction.
  always @(negedge clk) begin
    if (rst && issue_fire) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got inst=%h pc=%h, expected no issue", dec_inst, dec_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (dec_inst !== e.inst || dec_pc !== e.pc || dec_is_jump !== e.jmp) begin
          errors++;
          $display("FAIL issue_data: got inst=%h pc=%h jmp=%b, expected inst=%h pc=%h jmp=%b",
                   dec_inst, dec_pc, dec_is_jump, e.inst, e.pc, e.jmp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc, input logic jmp,
                       input bit will_issue);
    if_valid   = 1'b1;
    if_inst    = inst;
    if_pc      = pc;
    if_is_jump = jmp;
    if (will_issue) exp_q.push_back('{inst, pc, jmp});
    tick();
    if_valid = 1'b0;
  endtask

  initial begin
    // ---- reset values ----
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_if_full", 32'(if_full), 32'd0);
    chk("rst_dec_rdy", 32'(dec_inst_rdy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_dec_inst", dec_inst, 32'd0);
    chk("rst_dec_pc", dec_pc, 32'd0);
    chk("rst_dec_jmp", 32'(dec_is_jump), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // ---- single ADDI, all units free ----
    if_valid = 1'b1; if_inst = ADDI; if_pc = 32'h0; if_is_jump = 1'b0;
    #1 chk("t1_no_bypass", 32'(dec_inst_rdy), 32'd0);
    exp_q.push_back('{ADDI, 32'h0, 1'b0});
    tick();
    if_valid = 1'b0;
    chk("t1_count_push", 32'(count), 32'd1);
    @(negedge clk);
    chk("t1_dec_rdy", 32'(dec_inst_rdy), 32'd1);
    chk("t1_dec_pc", dec_pc, 32'h0);
    chk("t1_fire", 32'(issue_fire), 32'd1);
    tick();
    chk("t1_count_pop", 32'(count), 32'd0);

    // ---- fill to full with everything blocked, then drain ----
    rob_full = 1'b1; rs_full = 1'b1; lsb_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(ADDI + 32'(i << 7), 32'h10 + 32'(4 * i), 1'(i & 1), 1'b1);
      chk("t2_count_fill", 32'(count), 32'(i + 1));
    end
    chk("t2_if_full", 32'(if_full), 32'd1);
    if_valid = 1'b1; if_inst = ADDI + 32'h200; if_pc = 32'h20; if_is_jump = 1'b1;
    exp_q.push_back('{ADDI + 32'h200, 32'h20, 1'b1});
    tick();
    chk("t2_held_count", 32'(count), 32'd4);
    rob_full = 1'b0;
    @(negedge clk);
    chk("t2_rs_block", 32'(dec_inst_rdy), 32'd0);
    tick();
    rs_full = 1'b0;
    @(negedge clk);
    chk("t2_fire_e1", 32'(issue_fire), 32'd1);
    tick();
    chk("t2_count_e1", 32'(count), 32'd3);
    chk("t2_not_full", 32'(if_full), 32'd0);
    tick();
    if_valid = 1'b0;
    chk("t2_count_e2", 32'(count), 32'd3);
    tick();
    chk("t2_count_e3", 32'(count), 32'd2);
    tick();
    chk("t2_count_e4", 32'(count), 32'd1);
    tick();
    chk("t2_count_e5", 32'(count), 32'd0);

    // ---- opcode classes ----
    lsb_full = 1'b1; rs_full = 1'b0;
    offer(LW, 32'h100, 1'b0, 1'b1);
    @(negedge clk);
    chk("t3_lw_lsb_full", 32'(dec_inst_rdy), 32'd0);
    tick();
    lsb_full = 1'b0; rs_full = 1'b1;
    @(negedge clk);
    chk("t3_lw_rs_full", 32'(dec_inst_rdy), 32'd1);
    tick();
    chk("t3_lw_count", 32'(count), 32'd0);
    offer(SW, 32'h104, 1'b0, 1'b1);
    @(negedge clk);
    chk("t3_sw_issue", 32'(dec_inst_rdy), 32'd1);
    tick();
    lsb_full = 1'b1;
    offer(LUI, 32'h108, 1'b0, 1'b1);
    @(negedge clk);
    chk("t3_lui_issue", 32'(dec_inst_rdy), 32'd1);
    tick();
    chk("t3_lui_count", 32'(count), 32'd0);
    rs_full = 1'b0; lsb_full = 1'b0;

    // ---- rollback with a push in the same cycle ----
    rob_full = 1'b1;
    for (int i = 0; i < 3; i++) offer(ADDI, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
    chk("t4_count3", 32'(count), 32'd3);
    rollback = 1'b1; rob_full = 1'b0;
    if_valid = 1'b1; if_inst = ADDI + 32'h80; if_pc = 32'h280; if_is_jump = 1'b0;
    #1 chk("t4_rb_blocks_issue", 32'(dec_inst_rdy), 32'd0);
    exp_q.push_back('{ADDI + 32'h80, 32'h280, 1'b0});
    tick();
    rollback = 1'b0;
    chk("t4_count_flushed", 32'(count), 32'd0);
    @(negedge clk);
    chk("t4_flush_no_issue", 32'(dec_inst_rdy), 32'd0);
    tick();
    chk("t4_flush_no_push", 32'(count), 32'd0);
    tick();
    if_valid = 1'b0;
    chk("t4_push_after", 32'(count), 32'd1);
    @(negedge clk);
    chk("t4_fire_after", 32'(issue_fire), 32'd1);
    tick();

    // ---- halt ----
    offer(HALT, 32'h300, 1'b0, 1'b1);
    offer(ADDI, 32'h304, 1'b0, 1'b0);
    chk("t5_halted", 32'(halted), 32'd1);
    chk("t5_count", 32'(count), 32'd1);
    @(negedge clk);
    chk("t5_no_issue", 32'(dec_inst_rdy), 32'd0);
    tick();
    offer(ADDI, 32'h308, 1'b0, 1'b0);
    chk("t5_no_push", 32'(count), 32'd1);
    chk("t5_still_halted", 32'(halted), 32'd1);
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    chk("t5_rb_halted", 32'(halted), 32'd0);
    chk("t5_rb_count", 32'(count), 32'd0);
    tick();
    chk("t5_run_halted", 32'(halted), 32'd0);

    // ---- rdy low holds, then async reset ----
    rob_full = 1'b1;
    offer(ADDI, 32'h400, 1'b0, 1'b0);
    offer(ADDI, 32'h404, 1'b0, 1'b0);
    chk("t6_count2", 32'(count), 32'd2);
    rdy = 1'b0; rob_full = 1'b0;
    #1 chk("t6_rdy_low_issue", 32'(dec_inst_rdy), 32'd0);
    offer(ADDI, 32'h408, 1'b0, 1'b0);
    chk("t6_rdy_low_hold", 32'(count), 32'd2);
    rdy = 1'b1;
    #1 chk("t6_pre_rst_rdy", 32'(dec_inst_rdy), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_async_count", 32'(count), 32'd0);
    chk("t6_async_rdy", 32'(dec_inst_rdy), 32'd0);
    chk("t6_async_inst", dec_inst, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_after_rst", 32'(count), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
